// File: rtl/mux_scan_nx1.sv
// N-to-1 registered channel multiplexer with a manual select mode and an
// auto-scan mode that dwells on each enabled channel before moving on.
module mux_scan_nx1 #(
    parameter int N     = 8,
    parameter int W     = 1,
    parameter int DWELL = 4,
    localparam int SW   = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*W-1:0] i,
    input  logic [SW-1:0]  s,
    input  logic           mode,
    input  logic [N-1:0]   en_mask,
    output logic [W-1:0]   y,
    output logic [SW-1:0]  ch,
    output logic           valid,
    output logic [1:0]     fsm_state
);

    localparam logic [1:0] ST_MAN  = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [1:0]    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [SW-1:0] ch_n, base, nxt, entry;
    logic [W-1:0]  y_n;
    logic          valid_n, ch_on, man_ok;

    function automatic logic [W-1:0] pick(input logic [SW-1:0] k, input logic [N*W-1:0] d);
        logic [W-1:0] r;
        r = '0;
        for (int j = 0; j < N; j++) begin
            if (SW'(j) == k) r = d[j*W +: W];
        end
        return r;
    endfunction

    function automatic logic mask_bit(input logic [SW-1:0] k, input logic [N-1:0] m);
        logic r;
        r = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (SW'(j) == k) r = m[j];
        end
        return r;
    endfunction

    // First enabled channel strictly after base, wrapping; base itself is
    // considered last so a lone enabled channel finds itself again.
    function automatic logic [SW-1:0] next_above(input logic [SW-1:0] b, input logic [N-1:0] m);
        logic [SW-1:0] r;
        logic          found;
        int            idx;
        r     = b;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = int'(b) + k;
            if (idx >= N) idx = idx - N;
            if (!found && m[idx]) begin
                r     = SW'(idx);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    always_comb begin
        state_n = state;
        ch_n    = ch;
        cnt_n   = '0;
        y_n     = '0;
        valid_n = 1'b0;

        // An out-of-range ch (manual select past N-1) wraps to channel 0.
        base   = (32'(ch) < N) ? ch : SW'(N - 1);
        ch_on  = mask_bit(ch, en_mask);
        nxt    = next_above(base, en_mask);
        entry  = ch_on ? ch : nxt;
        man_ok = (32'(s) < N);

        if (!mode) begin
            state_n = ST_MAN;
            ch_n    = s;
            y_n     = man_ok ? pick(s, i) : '0;
            valid_n = man_ok;
        end else if (en_mask == '0) begin
            state_n = ST_HOLD;
        end else if (state == ST_SCAN) begin
            if (!ch_on || cnt == LAST) begin
                ch_n = nxt;
            end else begin
                cnt_n = cnt + CW'(1);
            end
            y_n     = pick(ch_n, i);
            valid_n = 1'b1;
        end else begin
            state_n = ST_SCAN;
            ch_n    = entry;
            y_n     = pick(entry, i);
            valid_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_MAN;
            cnt   <= '0;
            ch    <= '0;
            y     <= '0;
            valid <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            ch    <= ch_n;
            y     <= y_n;
            valid <= valid_n;
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_mux_scan_nx1.sv
// Bench for mux_scan_nx1: a behavioural model checks instance A every cycle,
// directed literal checks pin the model and cover a non-power-of-2 instance B.
module tb_mux_scan_nx1;

    localparam int NA = 8;
    localparam int WA = 8;
    localparam int DA = 4;
    localparam int NB = 6;
    localparam int WB = 4;
    localparam int DB = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NA*WA-1:0] a_i;
    logic [2:0]       a_s;
    logic             a_mode;
    logic [NA-1:0]    a_mask;
    logic [WA-1:0]    a_y;
    logic [2:0]       a_ch;
    logic             a_valid;
    logic [1:0]       a_st;

    logic [NB*WB-1:0] b_i;
    logic [2:0]       b_s;
    logic             b_mode;
    logic [NB-1:0]    b_mask;
    logic [WB-1:0]    b_y;
    logic [2:0]       b_ch;
    logic             b_valid;
    logic [1:0]       b_st;

    mux_scan_nx1 #(.N(NA), .W(WA), .DWELL(DA)) dut_a (
        .clk(clk), .rst(rst), .i(a_i), .s(a_s), .mode(a_mode), .en_mask(a_mask),
        .y(a_y), .ch(a_ch), .valid(a_valid), .fsm_state(a_st)
    );

    mux_scan_nx1 #(.N(NB), .W(WB), .DWELL(DB)) dut_b (
        .clk(clk), .rst(rst), .i(b_i), .s(b_s), .mode(b_mode), .en_mask(b_mask),
        .y(b_y), .ch(b_ch), .valid(b_valid), .fsm_state(b_st)
    );

    int checks = 0;
    int failures = 0;
    bit cmp_on = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of instance A.
    int         m_ch;
    int         m_cnt;
    logic [7:0] m_y;
    logic       m_valid;
    bit         m_scanning;

    function automatic int seek(input int from, input logic [NA-1:0] m, input bit incl);
        int idx;
        for (int k = (incl ? 0 : 1); k <= NA; k++) begin
            idx = (from + k) % NA;
            if (m[idx]) return idx;
        end
        return from;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_ch = 0; m_cnt = 0; m_y = 0; m_valid = 0; m_scanning = 0;
        end else if (!a_mode) begin
            m_scanning = 0; m_cnt = 0;
            m_ch = a_s;
            m_y = a_i[a_s*WA +: WA];
            m_valid = 1;
        end else if (a_mask == 0) begin
            m_scanning = 0; m_cnt = 0;
            m_y = 0; m_valid = 0;
        end else begin
            if (!m_scanning) begin
                m_ch = seek(m_ch, a_mask, 1);
                m_cnt = 0;
            end else if (!a_mask[m_ch] || m_cnt == DA - 1) begin
                m_ch = seek(m_ch, a_mask, 0);
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
            m_scanning = 1;
            m_y = a_i[m_ch*WA +: WA];
            m_valid = 1;
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("mdl_y", 32'(a_y), 32'(m_y));
            chk("mdl_ch", 32'(a_ch), 32'(m_ch));
            chk("mdl_valid", 32'(a_valid), 32'(m_valid));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] pat;
        int exp32[8];
        exp32 = '{1, 1, 1, 1, 0, 0, 0, 1};
        pat = 8'b10001111;

        rst = 1; a_i = '0; a_s = 0; a_mode = 0; a_mask = 0;
        b_s = 0; b_mode = 0; b_mask = 0;
        for (int k = 0; k < NB; k++) b_i[k*WB +: WB] = WB'(k + 8);
        tick(); tick();
        chk("rst_a_y", 32'(a_y), 0);
        chk("rst_a_ch", 32'(a_ch), 0);
        chk("rst_a_valid", 32'(a_valid), 0);
        chk("rst_b_valid", 32'(b_valid), 0);
        cmp_on = 1;
        rst = 0;

        // Manual stepping of a 1-bit pattern.
        for (int k = 0; k < NA; k++) a_i[k*WA +: WA] = 8'(pat[k]);
        for (int sv = 0; sv < 8; sv++) begin
            a_s = 3'(sv);
            for (int c = 0; c < 4; c++) begin
                tick();
                if (c == 0) begin
                    chk("man_y", 32'(a_y), 32'(exp32[sv]));
                    chk("man_valid", 32'(a_valid), 1);
                end
            end
        end

        // Full-mask scan, each channel held DWELL cycles.
        a_s = 0; tick();
        for (int k = 0; k < NA; k++) a_i[k*WA +: WA] = 8'(k);
        a_mask = 8'hFF; a_mode = 1;
        for (int c = 0; c < 36; c++) begin
            tick();
            chk("scan_ch", 32'(a_ch), 32'((c / 4) % 8));
            chk("scan_y", 32'(a_y), 32'((c / 4) % 8));
        end

        // Two enabled channels, then drop the current one mid-dwell.
        a_mode = 0; a_s = 0; tick();
        a_mask = 8'b00100010; a_mode = 1;
        for (int c = 0; c < 14; c++) begin
            tick();
            chk("two_ch", 32'(a_ch), ((c / 4) % 2) != 0 ? 5 : 1);
        end
        a_mask = 8'b00000010; tick();
        chk("drop_ch", 32'(a_ch), 1);

        // Empty mask holds, then recovers to the only enabled channel.
        a_mask = 0; tick();
        chk("hold_valid", 32'(a_valid), 0);
        chk("hold_y", 32'(a_y), 0);
        chk("hold_ch", 32'(a_ch), 1);
        chk("hold_state", 32'(a_st), 2);
        tick();
        a_mask = 8'h04; tick();
        chk("resume_ch", 32'(a_ch), 2);
        chk("resume_valid", 32'(a_valid), 1);
        chk("resume_y", 32'(a_y), 2);

        // Dwell expiry coinciding with a mask change uses the new mask.
        tick(); tick(); tick();
        a_mask = 8'h94; tick();
        chk("expiry_newmask_ch", 32'(a_ch), 4);

        // Single enabled channel stays put across dwell wraps.
        a_mask = 8'h08;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("single_ch", 32'(a_ch), 3);
        end

        // Reset mid-dwell, then immediate scan entry.
        a_mask = 8'hFF; tick(); tick();
        rst = 1; tick();
        chk("rstmid_y", 32'(a_y), 0);
        chk("rstmid_ch", 32'(a_ch), 0);
        chk("rstmid_valid", 32'(a_valid), 0);
        chk("rstmid_state", 32'(a_st), 0);
        rst = 0; tick();
        chk("post_rst_ch", 32'(a_ch), 0);
        chk("post_rst_state", 32'(a_st), 1);

        // Mixed soak, checked by the model.
        for (int c = 0; c < 300; c++) begin
            a_mode = ($urandom_range(0, 9) != 0);
            a_s = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 5) == 0)
                a_mask = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0)
                a_i[$urandom_range(0, 7)*WA +: WA] = 8'($urandom_range(0, 255));
            tick();
        end
        a_mode = 0;

        // N=6 instance: out-of-range select, wrap entry, DWELL=3.
        b_mode = 0; b_s = 7; tick();
        chk("b_oor_valid", 32'(b_valid), 0);
        chk("b_oor_y", 32'(b_y), 0);
        chk("b_oor_ch", 32'(b_ch), 7);
        b_s = 5; tick();
        chk("b_man_y", 32'(b_y), 13);
        chk("b_man_valid", 32'(b_valid), 1);
        b_s = 7; tick();
        b_mode = 1; b_mask = 6'b000100; tick();
        chk("b_wrap_ch", 32'(b_ch), 2);
        chk("b_wrap_y", 32'(b_y), 10);
        b_mode = 0; b_s = 0; tick();
        b_mode = 1; b_mask = 6'b100001;
        for (int c = 0; c < 9; c++) begin
            tick();
            chk("b_dwell_ch", 32'(b_ch), ((c / DB) % 2) != 0 ? 5 : 0);
        end
        rst = 1; tick();
        chk("b_rst_y", 32'(b_y), 0);
        chk("b_rst_ch", 32'(b_ch), 0);
        chk("b_rst_valid", 32'(b_valid), 0);
        chk("b_rst_state", 32'(b_st), 0);
        rst = 0; tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
